// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit: PC, IF/ID register and round counter for the vector crypto CPU;
// optional stall counter enabled by FETCH_STALL_CNT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
   parameter int         ADDR_W  = 8,
   parameter int         INSTR_W = 24,
   parameter logic [4:0] END_OP  = 5'b00000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic               id_valid,
   input  logic               id_ready,
   input  logic               ex_set_count,
   input  logic [3:0]         ex_set_value,
   input  logic               ex_dec_count,
   input  logic               ex_bnz,
   input  logic [ADDR_W-1:0]  ex_target,
   output logic [3:0]         round_count,
   output logic               count_zero,
   output logic               halted,
   output logic [15:0]        stall_cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t               state_q;
   logic [ADDR_W-1:0]    pc_q;
   logic [INSTR_W-1:0]   id_instr_q;
   logic [ADDR_W-1:0]    id_pc_q;
   logic                 id_valid_q;
   logic                 halted_q;
   logic [3:0]           cnt_q;
   logic [3:0]           cnt_d;
   logic                 zero_q;

   logic                 w_bnz_taken;
   logic                 w_stall;
   logic                 w_end_accept;

   // BNZ sees the counter value from before any same-cycle SETC/DEC.
   assign w_bnz_taken  = (state_q == S_RUN) && ex_bnz && (cnt_q != 4'd0);
   assign w_stall      = id_valid_q && !id_ready;
   assign w_end_accept = id_valid_q && id_ready &&
                         (id_instr_q[INSTR_W-1 -: 5] == END_OP);

   always_comb begin
      cnt_d = cnt_q;
      if (ex_set_count) begin
         cnt_d = ex_set_value;
      end else if (ex_dec_count && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         id_instr_q <= '0;
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
         halted_q   <= 1'b0;
         cnt_q      <= 4'd0;
         zero_q     <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == 4'd0);
         case (state_q)
            S_RUN: begin
               if (w_bnz_taken) begin
                  pc_q       <= ex_target;
                  id_valid_q <= 1'b0;
               end else if (w_stall) begin
                  pc_q       <= pc_q;
               end else if (w_end_accept) begin
                  state_q    <= S_HALT;
                  halted_q   <= 1'b1;
                  id_valid_q <= 1'b0;
               end else begin
                  id_instr_q <= imem_rdata;
                  id_pc_q    <= pc_q;
                  id_valid_q <= 1'b1;
                  pc_q       <= pc_q + ADDR_W'(1);
               end
            end
            default: begin
               if (start) begin
                  state_q    <= S_RUN;
                  halted_q   <= 1'b0;
                  pc_q       <= '0;
                  id_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 16'd0;
      end else if ((state_q != S_RUN) && start) begin
         stall_q <= 16'd0;
      end else if ((state_q == S_RUN) && w_stall && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 16'd0;
`endif

   assign imem_addr   = pc_q;
   assign id_instr    = id_instr_q;
   assign id_pc       = id_pc_q;
   assign id_valid    = id_valid_q;
   assign round_count = cnt_q;
   assign count_zero  = zero_q;
   assign halted      = halted_q;

endmodule

`default_nettype wire
